// File: rtl/serial_sum_pkg.sv
// rtl/serial_sum_pkg.sv - shared state encoding and default sizing for the serial sum link
package serial_sum_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_sum_watchdog.sv
// rtl/serial_sum_watchdog.sv - idle-cycle counter that pulses when a frame stalls too long
module serial_sum_watchdog
    import serial_sum_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic kick,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Fires on the TIMEOUT-th consecutive idle cycle while armed.
    assign expired = enable && !kick && (cnt_q == LAST);

    // Count idle cycles; any strobe, disarm or expiry restarts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (!enable || kick || expired) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_sum_collector.sv
// rtl/serial_sum_collector.sv - deserialises LSB-first sum/carry strobes into a handshaked word
module serial_sum_collector
    import serial_sum_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             bit_valid,
    input  logic             sum_bit,
    input  logic             carry_bit,
    output logic [WIDTH-1:0] word_data,
    output logic             word_carry,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overrun,
    output logic             timeout
);

    localparam int CNTW = $clog2(WIDTH) + 1;
    localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);

    state_e           state_q;
    logic [CNTW-1:0]  bit_cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] word_data_q;
    logic             word_carry_q;
    logic             word_valid_q;
    logic             overrun_q;
    logic             timeout_q;
    logic             wd_expired;

    serial_sum_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .enable  (state_q == ST_SHIFT),
        .kick    (bit_valid),
        .expired (wd_expired)
    );

    // Partial word with the current sum bit merged in; bits above bit_cnt are always zero.
    always_comb begin
        shift_d = shift_q | (WIDTH'(sum_bit) << bit_cnt_q);
    end

    // Frame FSM with registered outputs; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            word_data_q  <= '0;
            word_carry_q <= 1'b0;
            word_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bit_valid && frame_start) begin
                        shift_q   <= WIDTH'(sum_bit);
                        bit_cnt_q <= CNTW'(1);
                        state_q   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bit_valid) begin
                        if (frame_start) begin
                            shift_q   <= WIDTH'(sum_bit);
                            bit_cnt_q <= CNTW'(1);
                        end else if (bit_cnt_q == LAST_BIT) begin
                            word_data_q  <= shift_d;
                            word_carry_q <= carry_bit;
                            word_valid_q <= 1'b1;
                            shift_q      <= '0;
                            bit_cnt_q    <= '0;
                            state_q      <= ST_HOLD;
                        end else begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + CNTW'(1);
                        end
                    end else if (wd_expired) begin
                        timeout_q <= 1'b1;
                        shift_q   <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (bit_valid) begin
                        overrun_q <= 1'b1;
                    end
                    if (word_ready) begin
                        word_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign word_data  = word_data_q;
    assign word_carry = word_carry_q;
    assign word_valid = word_valid_q;
    assign overrun    = overrun_q;
    assign timeout    = timeout_q;

`ifdef FORMAL
    logic f_past_valid_q = 1'b0;

    // Marks cycles where $past() refers to a real earlier cycle.
    always_ff @(posedge clk) begin
        f_past_valid_q <= 1'b1;
    end

    // The first cycle is a reset cycle.
    always_comb begin
        if (!f_past_valid_q) begin
            assume (rst);
        end
    end

    // Safety properties over the registered state.
    always_ff @(posedge clk) begin
        if (f_past_valid_q && !$past(f_past_valid_q)) begin
            assert (!word_valid_q && state_q == ST_IDLE);
        end
        if (f_past_valid_q && !$past(rst) && !rst && $past(word_valid_q && !word_ready)) begin
            assert ($stable(word_data_q) && $stable(word_carry_q));
        end
        assert (bit_cnt_q < CNTW'(WIDTH));
        assert (!(overrun_q && timeout_q));
    end

    assume property (@(posedge clk) word_valid_q |-> s_eventually word_ready);
    assert property (@(posedge clk) disable iff (rst) word_valid_q |-> s_eventually !word_valid_q);
`endif

endmodule

// File: tb/tb_serial_sum_collector.sv
// tb/tb_serial_sum_collector.sv - scoreboard bench for serial_sum_collector
module tb_serial_sum_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic       bit_valid;
    logic       sum_bit;
    logic       carry_bit;
    logic [7:0] word_data;
    logic       word_carry;
    logic       word_valid;
    logic       word_ready;
    logic       overrun;
    logic       timeout;

    int checks   = 0;
    int failures = 0;
    int pushed   = 0;
    int popped   = 0;

    logic [8:0] exp_q[$];
    logic [8:0] mon_e;
    logic       first_ovr;

    serial_sum_collector #(
        .WIDTH   (8),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .bit_valid   (bit_valid),
        .sum_bit     (sum_bit),
        .carry_bit   (carry_bit),
        .word_data   (word_data),
        .word_carry  (word_carry),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .overrun     (overrun),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Apply inputs, let one rising edge sample them, return 1 time unit after that edge.
    task automatic drive(input logic fs, input logic bv, input logic s, input logic c);
        frame_start = fs;
        bit_valid   = bv;
        sum_bit     = s;
        carry_bit   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] w, input logic c, input bit push);
        if (push) begin
            exp_q.push_back({c, w});
            pushed++;
        end
        for (int i = 0; i < 8; i++) begin
            drive(i == 0, 1'b1, w[i], (i == 7) ? c : 1'b0);
            if (i == 0) first_ovr = overrun;
            if (i < 7) check("valid_early", word_valid, 0);
        end
        check("valid_latency", word_valid, 1);
    endtask

    // Scoreboard monitor: every accepted word must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && word_valid && word_ready) begin
            popped++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_extra_word actual=%0h required=none", word_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_data", word_data, mon_e[7:0]);
                check("sb_carry", word_carry, mon_e[8]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int t1_bits[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
        bit saw_valid;

        rst = 1'b1;
        word_ready = 1'b1;
        first_ovr = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        check("rst_valid", word_valid, 0);
        check("rst_data", word_data, 0);
        check("rst_carry", word_carry, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout, 0);
        rst = 1'b0;
        idle(2);

        // 1: spec vector, LSB first, expect 0x4D carry 1
        exp_q.push_back({1'b1, 8'h4D});
        pushed++;
        for (int i = 0; i < 8; i++) begin
            drive(i == 0, 1'b1, t1_bits[i][0], (i == 7) ? 1'b1 : 1'b0);
            if (i < 7) check("t1_valid_early", word_valid, 0);
        end
        check("t1_latency", word_valid, 1);
        check("t1_data", word_data, 8'h4D);
        idle(1);
        check("t1_released", word_valid, 0);

        // 2: stalled consumer, overrun strobe in HOLD
        word_ready = 1'b0;
        send_frame(8'hA5, 1'b0, 1);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) drive(1'b0, 1'b1, 1'b1, 1'b1);
            else        drive(1'b0, 1'b0, 1'b0, 1'b0);
            check("t2_held_valid", word_valid, 1);
            check("t2_held_data", {word_carry, word_data}, {1'b0, 8'hA5});
            if (k == 2) check("t2_overrun_pulse", overrun, 1);
            if (k == 3) check("t2_overrun_clear", overrun, 0);
        end
        word_ready = 1'b1;
        idle(1);
        check("t2_released", word_valid, 0);

        // 3: three strobes then watchdog abort on the 16th idle cycle
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        saw_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            idle(1);
            if (word_valid) saw_valid = 1'b1;
            if (k == 15) check("t3_no_early_timeout", timeout, 0);
            if (k == 16) check("t3_timeout_pulse", timeout, 1);
        end
        check("t3_no_valid", saw_valid, 0);
        idle(1);
        check("t3_timeout_clear", timeout, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        check("t3_stray_ignored", word_valid, 0);
        send_frame(8'h3C, 1'b0, 1);
        idle(1);

        // 4: five partial strobes, restart with frame_start, all-ones word
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1);
        idle(1);
        check("t4_single_valid", word_valid, 0);

        // 5a: reset in the middle of a frame
        for (int k = 0; k < 4; k++) drive(k == 0, 1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        check("t5a_data", word_data, 0);
        check("t5a_valid", word_valid, 0);
        check("t5a_carry", word_carry, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        check("t5a_idle_ignores", word_valid, 0);
        send_frame(8'h81, 1'b1, 1);
        idle(1);

        // 5b: reset while holding an unaccepted word
        word_ready = 1'b0;
        send_frame(8'hC3, 1'b1, 0);
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        check("t5b_valid", word_valid, 0);
        check("t5b_data", word_data, 0);
        check("t5b_carry", word_carry, 0);
        check("t5b_overrun", overrun, 0);
        word_ready = 1'b1;

        // 6: back-to-back frames, then a strobe in the handshake cycle
        send_frame(8'h96, 1'b1, 1);
        idle(1);
        check("t6_accepted", word_valid, 0);
        send_frame(8'h69, 1'b0, 1);
        check("t6_no_overrun", first_ovr, 0);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        check("t6_hs_overrun", overrun, 1);
        check("t6_hs_released", word_valid, 0);
        send_frame(8'h0F, 1'b1, 1);
        idle(3);

        check("sb_drained", exp_q.size(), 0);
        check("sb_word_count", popped, pushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
